div4_seq: RTL and testbench
===========================

# div4_seq

Sequential restoring divider: the inverse of the 4-bit array multiplier. It takes an 8-bit dividend (product width) and a 4-bit divisor (operand width) and returns an 8-bit quotient and a 4-bit remainder. It produces one quotient bit per clock, MSB first, under a start/busy/done handshake. It sits beside the multiplier in the ALU datapath, so a product can be divided back to recover an operand.

## Interface
- No parameters; widths fixed at 8-bit dividend, 4-bit divisor.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all outputs immediately.
- start  in  1  request; sampled on rising edge, acted on only in IDLE.
- A  in  8  dividend; captured on the accepting edge.
- B  in  4  divisor; captured on the accepting edge.
- Q  out  8  quotient; registered.
- R  out  4  remainder; registered.
- busy  out  1  high while in CALC.
- done  out  1  single-cycle pulse when Q/R/flags become valid.
- dz  out  1  divide-by-zero flag, valid with done.
- qovf  out  1  quotient exceeds 4 bits (Q[7:4] != 0), valid with done.

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE with Q=0, R=0, busy=0, done=0, dz=0, qovf=0, and all internal registers cleared.
- IDLE with start=1 and B!=0:
  - capture A into the shift register and B into the divisor register;
  - clear the partial remainder (5 bits) and set the bit counter to 7;
  - clear dz and qovf; go to CALC.
- IDLE with start=1 and B==0: go to DONE; Q=8'hFF, R=4'hF, dz=1, qovf=1.
- CALC, each cycle:
  - shift {rem, dividend MSB} left one bit;
  - trial = rem_shifted - {1'b0, B};
  - if trial >= 0, rem <= trial and the quotient bit is 1; otherwise rem is kept and the quotient bit is 0;
  - the quotient bit shifts into the LSB of the dividend register;
  - decrement the counter; on the cycle with counter==0, go to DONE.
- Entering DONE from CALC: Q = the final quotient register, R = rem[3:0], qovf = |Q[7:4], dz=0.
- DONE lasts exactly one cycle with done=1, then returns to IDLE. start in DONE is ignored.
- Q, R, dz and qovf hold their values in IDLE until the next accepted start. They are updated only on entry to DONE.
- start in CALC or DONE is ignored. A and B may change freely after the accepting edge.
- Arithmetic is unsigned. The invariant A = Q*B + R with R < B holds for every B != 0.

## Timing
- Accepting edge at cycle k: busy=1 during cycles k+1..k+8.
- done=1 during cycle k+9 only. Q/R are valid from k+9 and held after.
- Latency from start sample to done: 9 cycles for B!=0, 1 cycle for B==0 (done in cycle k+1, busy never asserted).
- Back-to-back operation: the earliest next accept is the edge ending the IDLE cycle after DONE, so throughput is 1 result per 10 cycles.
- reset asserted mid-CALC or mid-DONE: outputs clear asynchronously and the operation is abandoned. No done pulse follows deassertion.
- done and busy are never high in the same cycle.

## Test plan
- A=143, B=11, pulse start -> after 9 cycles done=1, Q=13, R=0, dz=0, qovf=0 (round-trips 11*13).
- A=100, B=7 -> Q=14, R=2, qovf=0; A=255, B=1 -> Q=255, R=0, qovf=1.
- A=200, B=0 -> done one cycle after start, busy never high, Q=8'hFF, R=4'hF, dz=1.
- Start A=50, B=3, then at CALC cycle 3 assert start with A=9, B=9 -> ignored; result Q=16, R=2, done at the original k+9.
- Start A=143, B=11; assert reset at CALC cycle 4 -> all outputs 0 immediately, no done within 20 cycles after release. Then A=0, B=15 -> Q=0, R=0.
- Exhaustive sweep of all A (0..255) and B (1..15) with back-to-back starts -> A == Q*B + R and R < B on every done, with exactly 10 cycles between accepts.

Source files
------------

// File: rtl/div4_seq.sv
`default_nettype none
// ============================================================================
//  Module   : div4_seq
//  Purpose  : Sequential restoring divider, 8-bit dividend by 4-bit divisor.
//             Produces one quotient bit per clock, MSB first, under a
//             start/busy/done handshake. Divide-by-zero completes in one cycle
//             with saturated results and the dz flag set.
//  Revision : 1.0  initial release
// ============================================================================
module div4_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [3:0] B,
    output logic [7:0] Q,
    output logic [3:0] R,
    output logic       busy,
    output logic       done,
    output logic       dz,
    output logic       qovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] dvd_q,  dvd_d;    // dividend shifting out, quotient shifting in
    logic [3:0] div_q,  div_d;    // captured divisor
    logic [4:0] rem_q,  rem_d;    // partial remainder
    logic [2:0] cnt_q,  cnt_d;    // remaining quotient bits minus one
    logic [7:0] q_q,    q_d;
    logic [3:0] r_q,    r_d;
    logic       dz_q,   dz_d;
    logic       qovf_q, qovf_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Datapath for one restoring step. The partial remainder is always below
    // the divisor (<= 14), so the shifted value fits in 5 bits and the extra
    // sixth bit of the trial result is purely the borrow.
    logic [4:0] rem_shift;
    logic [5:0] trial;
    logic       qbit;
    logic [7:0] quo_next;
    logic [4:0] rem_next;

    // Next-state and datapath computation for every register.
    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        div_d     = div_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        r_d       = r_q;
        dz_d      = dz_q;
        qovf_d    = qovf_q;

        rem_shift = {rem_q[3:0], dvd_q[7]};
        trial     = {1'b0, rem_shift} - {2'b00, div_q};
        qbit      = ~trial[5];
        quo_next  = {dvd_q[6:0], qbit};
        rem_next  = qbit ? trial[4:0] : rem_shift;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (B != 4'd0) begin
                        dvd_d   = A;
                        div_d   = B;
                        rem_d   = 5'd0;
                        cnt_d   = 3'd7;
                        dz_d    = 1'b0;
                        qovf_d  = 1'b0;
                        state_d = S_CALC;
                    end else begin
                        q_d     = 8'hFF;
                        r_d     = 4'hF;
                        dz_d    = 1'b1;
                        qovf_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_CALC: begin
                dvd_d = quo_next;
                rem_d = rem_next;
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    q_d     = quo_next;
                    r_d     = rem_next[3:0];
                    qovf_d  = |quo_next[7:4];
                    dz_d    = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered versions of the upcoming state.
        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            dvd_q   <= 8'd0;
            div_q   <= 4'd0;
            rem_q   <= 5'd0;
            cnt_q   <= 3'd0;
            q_q     <= 8'd0;
            r_q     <= 4'd0;
            dz_q    <= 1'b0;
            qovf_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            qovf_q  <= qovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign dz   = dz_q;
    assign qovf = qovf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_div4_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div4_seq
//  Purpose  : Directed self-checking bench for div4_seq.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div4_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] A;
    logic [3:0] B;
    logic [7:0] Q;
    logic [3:0] R;
    logic       busy;
    logic       done;
    logic       dz;
    logic       qovf;

    int n_checks = 0;
    int n_fails  = 0;

    div4_seq u_dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .qovf  (qovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Launch one operation and wait (bounded) for done. lat is the number of
    // cycles from the accepting edge to the done cycle (0 on timeout).
    task automatic do_op(input logic [7:0] a, input logic [3:0] b,
                         output int lat, output int nbusy, output time t_acc);
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk);
        t_acc = $time;
        #1;
        start = 1'b0;
        A = 8'($urandom);
        B = 4'($urandom);
        lat = 0; nbusy = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (busy && done) check_val("busy_done_overlap", 1, 0);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    int  lat, nbusy, ndone;
    time t_acc, t_prev;

    initial begin
        reset = 1'b1; start = 1'b0; A = 8'd0; B = 4'd0;
        repeat (2) @(negedge clk);
        check_val("rst_Q", 32'(Q), 0);
        check_val("rst_R", 32'(R), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_done", 32'(done), 0);
        check_val("rst_dz", 32'(dz), 0);
        check_val("rst_qovf", 32'(qovf), 0);
        reset = 1'b0;

        // 143 / 11 = 13 r 0
        do_op(8'd143, 4'd11, lat, nbusy, t_acc);
        check_val("143_lat", 32'(lat), 9);
        check_val("143_busy", 32'(nbusy), 8);
        check_val("143_Q", 32'(Q), 13);
        check_val("143_R", 32'(R), 0);
        check_val("143_dz", 32'(dz), 0);
        check_val("143_qovf", 32'(qovf), 0);

        // 100 / 7 = 14 r 2
        do_op(8'd100, 4'd7, lat, nbusy, t_acc);
        check_val("100_Q", 32'(Q), 14);
        check_val("100_R", 32'(R), 2);
        check_val("100_qovf", 32'(qovf), 0);

        // 255 / 1 = 255 r 0, quotient exceeds 4 bits
        do_op(8'd255, 4'd1, lat, nbusy, t_acc);
        check_val("255_Q", 32'(Q), 255);
        check_val("255_R", 32'(R), 0);
        check_val("255_qovf", 32'(qovf), 1);
        repeat (3) @(negedge clk);
        check_val("hold_Q", 32'(Q), 255);
        check_val("hold_done", 32'(done), 0);

        // Divide by zero: done one cycle after accept, no busy
        do_op(8'd200, 4'd0, lat, nbusy, t_acc);
        check_val("dz_lat", 32'(lat), 1);
        check_val("dz_busy", 32'(nbusy), 0);
        check_val("dz_Q", 32'(Q), 8'hFF);
        check_val("dz_R", 32'(R), 4'hF);
        check_val("dz_dz", 32'(dz), 1);
        check_val("dz_qovf", 32'(qovf), 1);

        // 50 / 3 with a start during CALC and another during DONE
        @(negedge clk);
        A = 8'd50; B = 4'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 3) begin
                A = 8'd9; B = 4'd9; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        check_val("ign_lat", 32'(lat), 9);
        check_val("ign_Q", 32'(Q), 16);
        check_val("ign_R", 32'(R), 2);
        A = 8'd9; B = 4'd9; start = 1'b1;   // presented during DONE
        @(negedge clk);
        start = 1'b0;
        check_val("ign_done_busy", 32'(busy), 0);
        check_val("ign_done_done", 32'(done), 0);
        check_val("ign_done_Q", 32'(Q), 16);

        // Reset during CALC abandons the operation
        @(negedge clk);
        A = 8'd143; B = 4'd11; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check_val("pre_rst_busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check_val("arst_Q", 32'(Q), 0);
        check_val("arst_R", 32'(R), 0);
        check_val("arst_busy", 32'(busy), 0);
        check_val("arst_done", 32'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check_val("arst_no_done", 32'(ndone), 0);
        do_op(8'd0, 4'd15, lat, nbusy, t_acc);
        check_val("zero_lat", 32'(lat), 9);
        check_val("zero_Q", 32'(Q), 0);
        check_val("zero_R", 32'(R), 0);

        // Back-to-back sweep of every dividend against every non-zero divisor
        t_prev = 0;
        for (int b = 1; b <= 15; b++) begin
            for (int a = 0; a <= 255; a++) begin
                do_op(8'(a), 4'(b), lat, nbusy, t_acc);
                check_val("sw_lat", 32'(lat), 9);
                check_val("sw_inv", 32'(Q) * 32'(b) + 32'(R), 32'(a));
                check_val("sw_rlt", 32'(32'(R) < 32'(b)), 1);
                check_val("sw_qovf", 32'(qovf), 32'((a / b) > 15));
                if (t_prev != 0)
                    check_val("sw_period", 32'(t_acc - t_prev), 100);
                t_prev = t_acc;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
